// File: rtl/quarter_round.sv
// ChaCha20 quarter round, one ARX step per clock.
// QR_SINGLE_CYCLE_EN: chain all four steps into one cycle.
module quarter_round #(
  parameter int ROT1 = 16,
  parameter int ROT2 = 12,
  parameter int ROT3 = 8,
  parameter int ROT4 = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [31:0] c_out,
  output logic [31:0] d_out,
  output logic        done
);

  function automatic logic [31:0] rotl(
    input logic [31:0] x,
    input int          r
  );
    return (x << r) | (x >> (32 - r));
  endfunction

  logic [31:0] ao_q, bo_q, co_q, do_q;
  logic [31:0] ao_d, bo_d, co_d, do_d;
  logic        done_q, done_d;

  assign a_out = ao_q;
  assign b_out = bo_q;
  assign c_out = co_q;
  assign d_out = do_q;
  assign done  = done_q;

`ifdef QR_SINGLE_CYCLE_EN

  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } state_e;

  state_e state_q, state_d;

  function automatic logic [127:0] qr_chain(
    input logic [31:0] ia,
    input logic [31:0] ib,
    input logic [31:0] ic,
    input logic [31:0] id
  );
    logic [31:0] wa, wb, wc, wd;
    wa = ia + ib;
    wd = rotl(id ^ wa, ROT1);
    wc = ic + wd;
    wb = rotl(ib ^ wc, ROT2);
    wa = wa + wb;
    wd = rotl(wd ^ wa, ROT3);
    wc = wc + wd;
    wb = rotl(wb ^ wc, ROT4);
    return {wa, wb, wc, wd};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) state_d = DONE;
  end

  always_comb begin
    {ao_d, bo_d, co_d, do_d} = {ao_q, bo_q, co_q, do_q};
    done_d = done_q;
    if (start) begin
      {ao_d, bo_d, co_d, do_d} = qr_chain(a, b, c, d);
      done_d = 1'b1;
    end
  end

`else

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    DONE = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [31:0] wa_q, wb_q, wc_q, wd_q;
  logic [31:0] wa_d, wb_d, wc_d, wd_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = S1;
      S1:         state_d = S2;
      S2:         state_d = S3;
      S3:         state_d = S4;
      S4:         state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    {wa_d, wb_d, wc_d, wd_d} = {wa_q, wb_q, wc_q, wd_q};
    {ao_d, bo_d, co_d, do_d} = {ao_q, bo_q, co_q, do_q};
    done_d = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          {wa_d, wb_d, wc_d, wd_d} = {a, b, c, d};
          done_d = 1'b0;
        end
      end
      S1: begin
        wa_d = wa_q + wb_q;
        wd_d = rotl(wd_q ^ wa_d, ROT1);
      end
      S2: begin
        wc_d = wc_q + wd_q;
        wb_d = rotl(wb_q ^ wc_d, ROT2);
      end
      S3: begin
        wa_d = wa_q + wb_q;
        wd_d = rotl(wd_q ^ wa_d, ROT3);
      end
      S4: begin
        wc_d = wc_q + wd_q;
        wb_d = rotl(wb_q ^ wc_d, ROT4);
        {ao_d, bo_d, co_d, do_d} = {wa_q, wb_d, wc_d, wd_q};
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wa_q <= '0;
      wb_q <= '0;
      wc_q <= '0;
      wd_q <= '0;
    end else begin
      wa_q <= wa_d;
      wb_q <= wb_d;
      wc_q <= wc_d;
      wd_q <= wd_d;
    end
  end

`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ao_q   <= '0;
      bo_q   <= '0;
      co_q   <= '0;
      do_q   <= '0;
      done_q <= 1'b0;
    end else begin
      ao_q   <= ao_d;
      bo_q   <= bo_d;
      co_q   <= co_d;
      do_q   <= do_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_quarter_round.sv
// Bench for quarter_round: directed RFC/boundary steps
// plus random ops against a word-array reference model.
module tb_quarter_round;

`ifdef QR_SINGLE_CYCLE_EN
  localparam int EXTRA = 0;
`else
  localparam int EXTRA = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0, c = '0, d = '0;
  logic [31:0] a_out, b_out, c_out, d_out;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic [127:0] rfc_exp;
  logic [127:0] last;
  logic [127:0] exp_v;

  quarter_round dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .a_out (a_out),
    .b_out (b_out),
    .c_out (c_out),
    .d_out (d_out),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rol(
    input logic [31:0] x,
    input int          r
  );
    logic [63:0] t;
    t = {x, x} << r;
    return t[63:32];
  endfunction

  // Reference: RFC quarter round on a 4-word array
  function automatic logic [127:0] model(
    input logic [31:0] ia,
    input logic [31:0] ib,
    input logic [31:0] ic,
    input logic [31:0] id
  );
    logic [31:0] w [4];
    int          rot [4];
    int          x, y, z;
    w[0] = ia; w[1] = ib; w[2] = ic; w[3] = id;
    rot[0] = 16; rot[1] = 12; rot[2] = 8; rot[3] = 7;
    for (int s = 0; s < 4; s++) begin
      x = (s % 2 == 0) ? 0 : 2;
      y = (s % 2 == 0) ? 1 : 3;
      z = (s % 2 == 0) ? 3 : 1;
      w[x] = 32'(w[x] + w[y]);
      w[z] = rol(w[z] ^ w[x], rot[s]);
    end
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [127:0] outs();
    return {a_out, b_out, c_out, d_out};
  endfunction

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] expv
  );
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    a = $urandom; b = $urandom;
    c = $urandom; d = $urandom;
  endtask

  task automatic issue(
    input logic [31:0] ia,
    input logic [31:0] ib,
    input logic [31:0] ic,
    input logic [31:0] id
  );
    start = 1'b1;
    a = ia; b = ib; c = ic; d = id;
    step();
    start = 1'b0;
    scramble();
  endtask

  // Runs one op, checks done timing, hold of old outputs, result
  task automatic run_op(
    input string        tag,
    input logic [31:0]  ia,
    input logic [31:0]  ib,
    input logic [31:0]  ic,
    input logic [31:0]  id,
    input logic [127:0] expv
  );
    issue(ia, ib, ic, id);
    for (int i = 0; i < EXTRA; i++) begin
      chk({tag, "_busy_done"}, 128'(done), 128'(0));
      chk({tag, "_busy_hold"}, outs(), last);
      step();
    end
    chk({tag, "_done"}, 128'(done), 128'(1));
    chk({tag, "_out"}, outs(), expv);
    last = expv;
  endtask

  initial begin
    rfc_exp = {32'hea2a92f4, 32'hcb1cf8ce,
               32'h4581472e, 32'h5881c4bb};
    last = '0;

    #12;
    chk("reset_out", outs(), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    step();
    reset = 1'b1;
    step();
    chk("idle_done", 128'(done), 128'(0));

    run_op("rfc", 32'h11111111, 32'h01020304,
           32'h9b8d6f43, 32'h01234567, rfc_exp);

    for (int i = 0; i < 20; i++) begin
      scramble();
      step();
      chk("hold", {127'(0), done}, 128'(1));
      chk("hold_out", outs(), rfc_exp);
    end

    run_op("zero_b2b", '0, '0, '0, '0, '0);

    run_op("rfc2", 32'h11111111, 32'h01020304,
           32'h9b8d6f43, 32'h01234567, rfc_exp);

`ifndef QR_SINGLE_CYCLE_EN
    // start pulse in S2 must be ignored
    issue(32'h11111111, 32'h01020304,
          32'h9b8d6f43, 32'h01234567);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_done_n2", 128'(done), 128'(0));
    step();
    chk("busy_done_n3", 128'(done), 128'(0));
    step();
    chk("busy_done_n4", 128'(done), 128'(1));
    chk("busy_out", outs(), rfc_exp);

    // asynchronous reset while in S3
    issue(32'h11111111, 32'h01020304,
          32'h9b8d6f43, 32'h01234567);
    step();
    step();
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_out", outs(), 128'(0));
    chk("rst_mid_done", 128'(done), 128'(0));
    step();
    chk("rst_low_done", 128'(done), 128'(0));
    reset = 1'b1;
    last = '0;
    step();
    chk("rst_rel_done", 128'(done), 128'(0));
    run_op("rfc_after_rst", 32'h11111111, 32'h01020304,
           32'h9b8d6f43, 32'h01234567, rfc_exp);
`endif

    for (int n = 0; n < 8; n++) begin
      logic [31:0] ra, rb, rc, rd;
      ra = $urandom; rb = $urandom;
      rc = $urandom; rd = $urandom;
      exp_v = model(ra, rb, rc, rd);
      run_op("rand", ra, rb, rc, rd, exp_v);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        step();
      chk("rand_hold", outs(), exp_v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
